// File: rtl/alsu_wide.sv
// alsu_wide: parametrised ALU/shift unit with a valid/ready request port,
// a one-cycle out_valid strobe, multi-cycle shift/rotate and an invalid-op
// LED toggle plus saturating error counter.
module alsu_wide #(
  parameter int unsigned WIDTH          = 8,
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned LED_W          = 16,
  parameter int unsigned ERR_W          = 8,
  localparam int unsigned OUT_W         = 2 * WIDTH,
  localparam int unsigned SH_W          = $clog2(OUT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic [SH_W-1:0]  shamt,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [LED_W-1:0] leds,
  output logic [ERR_W-1:0] err_count
);

  localparam bit PrioA  = (INPUT_PRIORITY != "B");
  localparam bit UseCin = (FULL_ADDER == "ON");

  typedef enum logic [1:0] {StIdle, StExec, StShift} state_e;

  state_e state_q, state_d;

  // Captured request
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, ser_q, dir_q, red_a_q, red_b_q, byp_a_q, byp_b_q;
  logic [SH_W-1:0]  shamt_q;

  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic                    accept, byp_any, invalid, is_shift;
  logic signed [OUT_W-1:0] a_ext, b_ext;
  logic [OUT_W-1:0]        byp_val, op_val, step_val, sum, prod;
  logic [WIDTH-1:0]        red_sel;

  assign accept  = in_valid & in_ready;
  assign byp_any = byp_a_q | byp_b_q;
  assign invalid = ((red_a_q | red_b_q) & (op_q[1] | op_q[2])) | (op_q[1] & op_q[2]);
  // Only opcodes 4/5 reach here as shifts; 6/7 are always invalid
  assign is_shift = ~byp_any & ~invalid & op_q[2];

  assign a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign sum     = a_ext + b_ext + OUT_W'(cin_q & UseCin);
  assign prod    = a_ext * b_ext;
  assign red_sel = (red_a_q && (PrioA || !red_b_q)) ? a_q : b_q;
  assign byp_val = (byp_a_q && (PrioA || !byp_b_q)) ? a_ext : b_ext;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = (is_shift && shamt_q > SH_W'(1)) ? StShift : StIdle;
      StShift: if (cnt_q == SH_W'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Result of the non-shift opcodes
  always_comb begin
    op_val = out_q;
    unique case (op_q)
      3'd0:    op_val = (red_a_q | red_b_q) ? OUT_W'(|red_sel) : (a_ext | b_ext);
      3'd1:    op_val = (red_a_q | red_b_q) ? OUT_W'(^red_sel) : (a_ext ^ b_ext);
      3'd2:    op_val = sum;
      3'd3:    op_val = prod;
      default: op_val = out_q;
    endcase
  end

  // One shift/rotate step of the current out register; op_q[0] selects rotate
  always_comb begin
    if (dir_q) step_val = {out_q[OUT_W-2:0], op_q[0] ? out_q[OUT_W-1] : ser_q};
    else       step_val = {op_q[0] ? out_q[0] : ser_q, out_q[OUT_W-1:1]};
  end

  // Datapath next state
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    leds_d  = leds_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StExec: begin
        if (byp_any) begin
          out_d   = byp_val;
          valid_d = 1'b1;
        end else if (invalid) begin
          out_d   = '0;
          valid_d = 1'b1;
          leds_d  = ~leds_q;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end else if (is_shift) begin
          if (shamt_q != '0) out_d = step_val;
          cnt_d = shamt_q - SH_W'(1);
          if (shamt_q <= SH_W'(1)) begin
            valid_d = 1'b1;
            leds_d  = '0;
          end
        end else begin
          out_d   = op_val;
          valid_d = 1'b1;
          leds_d  = '0;
        end
      end
      StShift: begin
        out_d = step_val;
        cnt_d = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          valid_d = 1'b1;
          leds_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      leds_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      ser_q   <= 1'b0;
      dir_q   <= 1'b0;
      shamt_q <= '0;
      red_a_q <= 1'b0;
      red_b_q <= 1'b0;
      byp_a_q <= 1'b0;
      byp_b_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= opcode;
        a_q     <= A;
        b_q     <= B;
        cin_q   <= cin;
        ser_q   <= serial_in;
        dir_q   <= direction;
        shamt_q <= shamt;
        red_a_q <= red_op_A;
        red_b_q <= red_op_B;
        byp_a_q <= bypass_A;
        byp_b_q <= bypass_B;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign leds      = leds_q;
  assign err_count = err_q;

endmodule
